// File: rtl/mux_n_pipe_pkg.sv
// Shared constants and helpers for the N-channel pipelined selector.
package mux_n_pipe_pkg;

   localparam int MUX_MODE_FIXED = 0;
   localparam int MUX_MODE_RR    = 1;

   function automatic int mux_clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/pipe_buf2.sv
// Two-entry FIFO; head is always the oldest entry and stays stable while
// it is not popped.
module pipe_buf2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head_data,
   output logic         valid,
   output logic         full
);

   logic [1:0]   cnt_q, cnt_d;
   logic [W-1:0] head_q, head_d;
   logic [W-1:0] tail_q, tail_d;
   logic         push_ok, pop_ok;

   assign push_ok = push && (cnt_q != 2'd2);
   assign pop_ok  = pop && (cnt_q != 2'd0);

   always_comb begin
      cnt_d  = cnt_q;
      head_d = head_q;
      tail_d = tail_q;
      if (flush) begin
         cnt_d = 2'd0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (cnt_q == 2'd0) head_d = push_data;
               else tail_d = push_data;
               cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
               head_d = tail_q;
               cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
               // simultaneous push/pop keeps the count; the new entry
               // lands behind whatever survives the pop
               if (cnt_q == 2'd1) begin
                  head_d = push_data;
               end else begin
                  head_d = tail_q;
                  tail_d = push_data;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   assign head_data = head_q;
   assign valid     = (cnt_q != 2'd0);
   assign full      = (cnt_q == 2'd2);

endmodule

// File: rtl/mux_n_pipe.sv
// N-channel selector (fixed or round-robin) feeding a registered
// two-entry output buffer with valid/ready handshakes.
module mux_n_pipe
   import mux_n_pipe_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SEL_W = mux_clog2(N),
   parameter int MODE  = MUX_MODE_FIXED
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SEL_W-1:0]   sel,
   input  logic               flush,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_src,
   output logic               out_valid,
   input  logic               out_ready
);

   localparam int EW = WIDTH + SEL_W;

   logic [SEL_W-1:0] rr_q, rr_d;
   logic [SEL_W-1:0] grant;
   logic             grant_ok;
   logic [WIDTH-1:0] grant_data;
   logic             grant_vld;
   logic             rdy_ok, full, push, pop;
   logic [EW-1:0]    head;
   int               idx;

   // scan downward so the lowest offset from rr_ptr wins
   always_comb begin
      grant    = '0;
      grant_ok = 1'b0;
      idx      = 0;
      if (MODE == MUX_MODE_RR) begin
         for (int k = N - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= N) idx = idx - N;
            if (in_valid[idx]) begin
               grant    = SEL_W'(idx);
               grant_ok = 1'b1;
            end
         end
      end else begin
         grant    = sel;
         grant_ok = (int'(sel) < N);
      end
   end

   always_comb begin
      grant_data = '0;
      grant_vld  = 1'b0;
      in_ready   = '0;
      rdy_ok     = grant_ok && !full && !flush && rst_n;
      for (int i = 0; i < N; i++) begin
         if (grant_ok && grant == SEL_W'(i)) begin
            grant_data  = in_data[i*WIDTH +: WIDTH];
            grant_vld   = in_valid[i];
            in_ready[i] = rdy_ok;
         end
      end
   end

   assign push = rdy_ok && grant_vld;
   assign pop  = out_valid && out_ready;

   always_comb begin
      rr_d = rr_q;
      if (flush) begin
         rr_d = '0;
      end else if (push && MODE == MUX_MODE_RR) begin
         if (int'(grant) + 1 >= N) rr_d = '0;
         else rr_d = grant + SEL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_q <= '0;
      else rr_q <= rr_d;
   end

   pipe_buf2 #(
      .W(EW)
   ) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .push     (push),
      .push_data({grant_data, grant}),
      .pop      (pop),
      .head_data(head),
      .valid    (out_valid),
      .full     (full)
   );

   assign out_data = head[EW-1:SEL_W];
   assign out_src  = head[SEL_W-1:0];

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed checks of fixed-select and round-robin mux_n_pipe instances.
module tb_mux_n_pipe;

   logic clk;
   logic rst_n;

   logic [127:0] in_data0;
   logic [3:0]   in_valid0, in_ready0;
   logic [2:0]   sel0, out_src0;
   logic         flush0, out_valid0, out_ready0;
   logic [31:0]  out_data0;

   logic [127:0] in_data1;
   logic [3:0]   in_valid1, in_ready1;
   logic [1:0]   sel1, out_src1;
   logic         flush1, out_valid1, out_ready1;
   logic [31:0]  out_data1;

   int checks;
   int errors;

   mux_n_pipe #(
      .WIDTH(32), .N(4), .SEL_W(3), .MODE(0)
   ) u_fix (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
      .sel(sel0), .flush(flush0),
      .out_data(out_data0), .out_src(out_src0),
      .out_valid(out_valid0), .out_ready(out_ready0)
   );

   mux_n_pipe #(
      .WIDTH(32), .N(4), .MODE(1)
   ) u_rr (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
      .sel(sel1), .flush(flush1),
      .out_data(out_data1), .out_src(out_src1),
      .out_valid(out_valid1), .out_ready(out_ready1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] seq_all [5];
      logic [1:0] seq_odd [4];
      seq_all = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      seq_odd = '{2'd1, 2'd3, 2'd1, 2'd3};
      checks = 0;
      errors = 0;

      rst_n = 1'b0;
      in_data0 = '0; in_valid0 = 4'hF; sel0 = 3'd2;
      flush0 = 1'b0; out_ready0 = 1'b1;
      in_data1 = '0; in_valid1 = 4'hF; sel1 = 2'd0;
      flush1 = 1'b0; out_ready1 = 1'b1;
      for (int i = 0; i < 4; i++) in_data1[i*32 +: 32] = 32'hA0 + i;

      // reset held with all valids high
      tick();
      tick();
      check("rst_ovalid0", out_valid0, 0);
      check("rst_odata0", out_data0, 0);
      check("rst_ird0", in_ready0, 0);
      check("rst_ird1", in_ready1, 0);
      check("rst_ovalid1", out_valid1, 0);

      in_valid0 = 4'h0;
      in_valid1 = 4'h0;
      rst_n = 1'b1;
      #1;
      check("rel_ird0", in_ready0, 4'b0100);

      // fixed select, channel 2
      in_data0[2*32 +: 32] = 32'hDEADBEEF;
      in_valid0 = 4'b0100;
      tick();
      in_valid0 = 4'h0;
      check("fix_ovalid", out_valid0, 1);
      check("fix_odata", out_data0, 32'hDEADBEEF);
      check("fix_osrc", out_src0, 2);
      tick();
      check("fix_drain", out_valid0, 0);

      // out-of-range select
      sel0 = 3'd5;
      in_valid0 = 4'hF;
      #1;
      check("oor_ird", in_ready0, 0);
      tick();
      check("oor_nopush", out_valid0, 0);
      in_valid0 = 4'h0;
      sel0 = 3'd0;

      // back-pressure
      out_ready0 = 1'b0;
      in_data0[31:0] = 32'h11;
      in_valid0 = 4'b0001;
      #1;
      check("bp_ird_c1", in_ready0, 4'b0001);
      tick();
      in_data0[31:0] = 32'h22;
      check("bp_ird_c2", in_ready0, 4'b0001);
      tick();
      check("bp_ird_c3", in_ready0, 0);
      check("bp_head", out_data0, 32'h11);
      in_valid0 = 4'h0;
      tick();
      check("bp_stable", out_data0, 32'h11);
      check("bp_ovalid", out_valid0, 1);
      out_ready0 = 1'b1;
      #1;
      check("bp_ird_nodep", in_ready0, 0);
      tick();
      check("bp_pop1", out_data0, 32'h22);
      check("bp_ird_back", in_ready0, 4'b0001);
      tick();
      check("bp_empty", out_valid0, 0);

      // round-robin, all valid
      in_valid1 = 4'hF;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rr_all_src", out_src1, seq_all[i]);
         check("rr_all_data", out_data1, 32'hA0 + seq_all[i]);
      end
      in_valid1 = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rr_odd_src", out_src1, seq_odd[i]);
      end
      in_valid1 = 4'h0;
      tick();
      check("rr_drain", out_valid1, 0);

      // flush with a full buffer and a pop offered
      out_ready1 = 1'b0;
      in_valid1 = 4'hF;
      tick();
      tick();
      check("fl_full_ird", in_ready1, 0);
      out_ready1 = 1'b1;
      flush1 = 1'b1;
      #1;
      check("fl_ird", in_ready1, 0);
      tick();
      flush1 = 1'b0;
      in_valid1 = 4'h0;
      check("fl_ovalid", out_valid1, 0);
      in_valid1 = 4'hF;
      #1;
      check("fl_rr0", in_ready1, 4'b0001);
      tick();
      check("fl_src0", out_src1, 0);
      in_valid1 = 4'h0;
      tick();

      // async reset mid-stream
      out_ready0 = 1'b0;
      in_valid0 = 4'b0001;
      in_data0[31:0] = 32'h33;
      tick();
      in_data0[31:0] = 32'h44;
      tick();
      in_valid0 = 4'h0;
      check("ar_pre", out_data0, 32'h33);
      #3;
      rst_n = 1'b0;
      #1;
      check("ar_ovalid", out_valid0, 0);
      check("ar_odata", out_data0, 0);
      check("ar_osrc", out_src0, 0);
      check("ar_ird", in_ready0, 0);
      #2;
      rst_n = 1'b1;
      out_ready0 = 1'b1;
      tick();
      check("ar_stale1", out_valid0, 0);
      tick();
      check("ar_stale2", out_valid0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_n_pipe.md
# mux_n_pipe

Parametrised N-channel, WIDTH-bit selector with a registered, handshaked output stage for the pipeline datapath. It supersedes the combinational 2:1 and 4:1 selectors wherever the selected value must cross a stall/flush boundary. Two selection modes are supported: fixed select from an external index, or round-robin arbitration among valid channels. A 2-entry output buffer decouples input acceptance from downstream back-pressure.

## Interface
- WIDTH, 32, data width per channel (1..64)
- N, 4, channel count (2..16)
- SEL_W, $clog2(N), select/source index width
- MODE, 0, 0 = fixed select via `sel`; 1 = round-robin among valid channels (`sel` ignored)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  per-channel valid
- in_ready  out  N  per-channel ready; at most one bit high per cycle
- sel  in  SEL_W  channel index (MODE 0 only)
- flush  in  1  synchronous pipeline flush
- out_data  out  WIDTH  head-entry data
- out_src  out  SEL_W  channel index the head entry came from
- out_valid  out  1  head entry present
- out_ready  in  1  downstream accepts head

## Operation
- Grant g: MODE 0 → g = sel; sel ≥ N → no grant, all in_ready low. MODE 1 → first i with in_valid[i] high, scanning from rr_ptr upward, wrapping at N; none valid → no grant.
- in_ready[g] = (count < 2) && !flush && rst_n; all other bits 0. In MODE 1, in_ready is zero when no channel is valid. in_ready depends only on registered state, `sel`/`in_valid` and `flush`. It never depends on out_ready.
- Push: in_valid[g] && in_ready[g] → {in_data[g], g} is written at the tail.
- Pop: out_valid && out_ready → head is removed.
- count ∈ {0,1,2}. Push only → +1. Pop only → −1. Push and pop together → unchanged, and the pushed entry becomes head when count was 1. Push at count 2 cannot occur.
- rr_ptr (MODE 1): after an accepted push from g, rr_ptr ← (g+1) mod N. It is unchanged when no push occurs.
- flush: at the next edge count ← 0 and rr_ptr ← 0. A pop presented in the same cycle is discarded. No push is accepted in the flush cycle.
- Reset (async assert): count 0, rr_ptr 0, out_valid 0, out_data 0, out_src 0. Release is synchronous to the next clk edge. Reset mid-transfer discards all buffered entries.

## Timing
- Latency: a push at edge k gives out_valid = 1 and out_data = pushed value after edge k (visible in cycle k+1). Nothing passes combinationally from input to output.
- Throughput: one transfer per cycle while out_ready is held high, with count oscillating ≤ 1.
- Back-pressure: with out_ready low, two pushes are accepted and in_ready then drops in the cycle after the second push. When out_ready rises, the first pop re-enables in_ready in the following cycle.
- out_data and out_src stay stable while out_valid && !out_ready.
- out_valid falls the cycle after flush and the cycle after the last pop.

## Structure
- Shared package/header holds the MUX_MODE_FIXED = 0 and MUX_MODE_RR = 1 constants and the clog2 helper used for SEL_W.
- Sub-module pipe_buf2: a 2-entry FIFO of width WIDTH+SEL_W with push/pop/flush and a full flag. mux_n_pipe instantiates it and contains only grant logic, rr_ptr and ready generation.

## Test plan
- Reset: hold rst_n low with all in_valid high → out_valid 0, out_data 0, in_ready all 0. Release → in_ready[sel] = 1 in the first cycle.
- MODE 0, N=4, sel=2, in_data[2]=0xDEADBEEF valid, out_ready=1 → out_data 0xDEADBEEF and out_src 2 one cycle later. Set sel=5 on an N=4 instance → all in_ready 0 and no pushes.
- Back-pressure: out_ready=0, push 0x11 then 0x22 → in_ready low from the third cycle. Raise out_ready → pops 0x11, then 0x22, in order.
- MODE 1, N=4, all channels valid continuously, out_ready=1 → out_src sequence 0,1,2,3,0. With only channels 1 and 3 valid → 1,3,1,3.
- Flush with count=2 and out_ready=1 in the same cycle → next cycle out_valid 0, count 0, no pop observed, rr_ptr 0.
- Async reset asserted mid-stream between clock edges → outputs clear immediately. After release, no stale entries appear.
